// File: rtl/vm_coin_acceptor_if.sv
// FSM-facing credit bus of the coin acceptor: deduct/clear requests in,
// credit and per-coin event pulses out.
interface vm_coin_acceptor_if #(
  parameter int unsigned CW = 8
);
  logic          credit_sub_en;
  logic [CW-1:0] credit_sub_amt;
  logic          credit_clr;
  logic [CW-1:0] credit;
  logic          coin_valid;
  logic [7:0]    coin_value;
  logic          coin_reject;
  logic          sub_err;

  modport master (
    output credit_sub_en, credit_sub_amt, credit_clr,
    input  credit, coin_valid, coin_value, coin_reject, sub_err
  );

  modport slave (
    input  credit_sub_en, credit_sub_amt, credit_clr,
    output credit, coin_valid, coin_value, coin_reject, sub_err
  );
endinterface

// File: rtl/vm_coin_acceptor.sv
// Coin acceptor: synchronise and debounce three coin sensors, classify rising
// coin events and keep a saturation-checked credit register for the vend FSM.
module vm_coin_acceptor #(
  parameter int unsigned CW         = 8,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned DEBOUNCE   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 coin_10_in,
  input  logic                 coin_20_in,
  input  logic                 coin_50_in,
  vm_coin_acceptor_if.slave    bus
);

  localparam int unsigned NCH = 3;
  localparam int unsigned DBW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] MAX_C = (CW + 1)'(MAX_CREDIT);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0] cnt_q [NCH];
  logic [DBW-1:0] cnt_d [NCH];

  logic [NCH-1:0] rise;
  logic           one_coin, multi_coin;
  logic [7:0]     coin_v;
  logic [CW:0]    base, sum;

  logic [CW-1:0]  credit_q, credit_d;
  logic           valid_q, valid_d;
  logic [7:0]     value_q, value_d;
  logic           reject_q, reject_d;
  logic           sub_err_q, sub_err_d;

  assign raw = {coin_50_in, coin_20_in, coin_10_in};

  // Debounce: count consecutive samples that disagree with the held level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DBW'(DEBOUNCE - 1)) deb_d[i] = sync2_q[i];
        else                                cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise       = deb_q & ~deb_prev_q;
  assign one_coin   = $onehot(rise);
  assign multi_coin = (rise != '0) && !one_coin;

  always_comb begin
    coin_v = 8'd0;
    case (rise)
      3'b001:  coin_v = 8'd10;
      3'b010:  coin_v = 8'd20;
      3'b100:  coin_v = 8'd50;
      default: coin_v = 8'd0;
    endcase
  end

  // Credit step: clear, then deduct, then add; one extra bit so adds never wrap.
  always_comb begin
    credit_d  = credit_q;
    valid_d   = 1'b0;
    value_d   = 8'd0;
    reject_d  = 1'b0;
    sub_err_d = 1'b0;
    base      = bus.credit_clr ? '0 : {1'b0, credit_q};
    if (bus.credit_sub_en && !bus.credit_clr) begin
      if ({1'b0, bus.credit_sub_amt} <= base) base = base - {1'b0, bus.credit_sub_amt};
      else                                    sub_err_d = 1'b1;
    end
    sum = base + (CW + 1)'(coin_v);
    credit_d = base[CW-1:0];
    if (one_coin) begin
      if (sum <= MAX_C) begin
        credit_d = sum[CW-1:0];
        valid_d  = 1'b1;
        value_d  = coin_v;
      end else begin
        reject_d = 1'b1;
      end
    end else if (multi_coin) begin
      reject_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      credit_q   <= '0;
      valid_q    <= 1'b0;
      value_q    <= 8'd0;
      reject_q   <= 1'b0;
      sub_err_q  <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      credit_q   <= credit_d;
      valid_q    <= valid_d;
      value_q    <= value_d;
      reject_q   <= reject_d;
      sub_err_q  <= sub_err_d;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.coin_valid  = valid_q;
  assign bus.coin_value  = value_q;
  assign bus.coin_reject = reject_q;
  assign bus.sub_err     = sub_err_q;

endmodule
